// File: rtl/prec_mul_scheduler.sv
// Precision-aware multiplier scheduler: slot-table issue, out-of-order writeback.
// Define PMS_STATS_EN to build the saturating stall counter behind stall_cnt.
module prec_mul_scheduler #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [3:0]       in_prec,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_last,
    output logic             mul_valid,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [7:0]       mul_p4,
    input  logic [15:0]      mul_p8,
    input  logic [31:0]      mul_p16,
    output logic             wb_valid,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic [1:0]       wb_prec,
    output logic             busy,
    output logic             done,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic             res;
        logic [TAG_W-1:0] tag;
        logic [1:0]       prec;
    } slot_t;

    state_t     state_q, state_d;
    slot_t      slot_q   [1:5];
    slot_t      slot_d   [1:5];
    slot_t      res_next [1:5];
    slot_t      new_slot;
    logic [1:0] cls;
    logic       hit;
    logic       xfer;
    logic       pending;

    // Index k of slot_q means "writes back k-1 cycles from now"; index 1 drives wb.
    always_comb begin
        for (int k = 1; k < 5; k++) begin
            res_next[k] = slot_q[k+1];
        end
        res_next[5] = '0;
    end

    always_comb begin
        cls = 2'd2;
        if (in_prec == 4'd0) begin
            cls = 2'd0;
        end else if (in_prec == 4'd1) begin
            cls = 2'd1;
        end
    end

    always_comb begin
        hit = 1'b0;
        unique case (cls)
            2'd0:    hit = res_next[2].res;
            2'd1:    hit = res_next[3].res;
            default: hit = res_next[5].res;
        endcase
    end

    assign in_ready  = (state_q == S_RUN) && !hit;
    assign xfer      = in_valid && in_ready;
    assign mul_valid = xfer;
    assign mul_a     = xfer ? in_a : 16'd0;
    assign mul_b     = xfer ? in_b : 16'd0;
    assign new_slot  = '{res: 1'b1, tag: in_tag, prec: cls};

    always_comb begin
        slot_d = res_next;
        if (xfer) begin
            unique case (cls)
                2'd0:    slot_d[2] = new_slot;
                2'd1:    slot_d[3] = new_slot;
                default: slot_d[5] = new_slot;
            endcase
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pending = pending | res_next[k].res;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (xfer && in_last) state_d = S_DRAIN;
            S_DRAIN: if (!pending) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int k = 1; k <= 5; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign wb_valid = slot_q[1].res;
    assign wb_tag   = slot_q[1].tag;
    assign wb_prec  = slot_q[1].prec;

    // Product ports are live in the retire cycle, so data muxes straight through.
    always_comb begin
        wb_data = 32'd0;
        if (wb_valid) begin
            unique case (wb_prec)
                2'd0:    wb_data = {24'd0, mul_p4};
                2'd1:    wb_data = {16'd0, mul_p8};
                default: wb_data = mul_p16;
            endcase
        end
    end

`ifdef PMS_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = 16'd0;
        end else if (state_q == S_RUN && in_valid && !in_ready &&
                     stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_prec_mul_scheduler.sv
// Randomized + directed bench for prec_mul_scheduler against a cycle-indexed
// reservation model; the multiplier is modelled with fixed 2/3/5 latencies.
module tb_prec_mul_scheduler;

    localparam int TAG_W = 6;

`ifdef PMS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = '0;
    logic [15:0]      in_b = '0;
    logic [3:0]       in_prec = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_last = 1'b0;
    logic             mul_valid;
    logic [15:0]      mul_a;
    logic [15:0]      mul_b;
    logic [7:0]       mul_p4;
    logic [15:0]      mul_p8;
    logic [31:0]      mul_p16;
    logic             wb_valid;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic [1:0]       wb_prec;
    logic             busy;
    logic             done;
    logic [15:0]      stall_cnt;

    always #5 clk = ~clk;

    prec_mul_scheduler #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_prec(in_prec),
        .in_tag(in_tag), .in_last(in_last),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p4(mul_p4), .mul_p8(mul_p8), .mul_p16(mul_p16),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag),
        .wb_prec(wb_prec), .busy(busy), .done(done),
        .stall_cnt(stall_cnt)
    );

    function automatic logic [31:0] prod(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input int c);
        logic [31:0] x, y;
        if (c == 0) begin
            x = {28'd0, a[3:0]};
            y = {28'd0, b[3:0]};
        end else if (c == 1) begin
            x = {24'd0, a[7:0]};
            y = {24'd0, b[7:0]};
        end else begin
            x = {16'd0, a};
            y = {16'd0, b};
        end
        return x * y;
    endfunction

    function automatic int cls_of(input logic [3:0] p);
        return (p == 4'd0) ? 0 : (p == 4'd1) ? 1 : 2;
    endfunction

    function automatic int lat_of(input logic [3:0] p);
        return (p == 4'd0) ? 2 : (p == 4'd1) ? 3 : 5;
    endfunction

    // External multiplier: product on the port exactly Lc cycles after launch.
    logic [5:0]  hv = '0;
    logic [15:0] ha [0:5];
    logic [15:0] hb [0:5];

    always @(posedge clk) begin
        hv    <= {hv[4:0], mul_valid};
        ha[0] <= mul_a;
        hb[0] <= mul_b;
        for (int i = 1; i < 6; i++) begin
            ha[i] <= ha[i-1];
            hb[i] <= hb[i-1];
        end
    end

    assign mul_p4  = hv[1] ? 8'(prod(ha[1], hb[1], 0)) : 8'hA5;
    assign mul_p8  = hv[2] ? 16'(prod(ha[2], hb[2], 1)) : 16'h5AA5;
    assign mul_p16 = hv[4] ? prod(ha[4], hb[4], 2) : 32'hDEAD_BEEF;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tg, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tg, got, exp, $time);
        end
    endtask

    // Reference model: reservations keyed by absolute writeback cycle.
    int               cyc = 0;
    int               mst = 0;
    int               ecnt = 0;
    bit               resv [64];
    logic [31:0]      edat [64];
    logic [TAG_W-1:0] etg  [64];
    logic [1:0]       epr  [64];

    int          iss_log[$];
    int          wbc_log[$];
    logic [31:0] wbd_log[$];
    int          done_log[$];

    typedef struct {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [3:0]       p;
        logic [TAG_W-1:0] t;
        int               gap;
    } op_t;

    op_t ops[$];

    task automatic model_clear();
        mst  = 0;
        ecnt = 0;
        for (int i = 0; i < 64; i++) begin
            resv[i] = 1'b0;
        end
    endtask

    task automatic clear_logs();
        iss_log.delete();
        wbc_log.delete();
        wbd_log.delete();
        done_log.delete();
    endtask

    task automatic tick(output bit xf);
        bit er;
        bit pend;
        int s;
        int l;
        @(negedge clk);
        s  = cyc % 64;
        l  = lat_of(in_prec);
        er = (mst == 1) && !resv[(cyc + l) % 64];
        xf = in_valid && er;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("mul_valid", 32'(mul_valid), 32'(xf));
        chk("mul_ab", {mul_a, mul_b}, xf ? {in_a, in_b} : 32'd0);
        chk("wb_valid", 32'(wb_valid), 32'(resv[s]));
        if (resv[s]) begin
            chk("wb_data", wb_data, edat[s]);
            chk("wb_tag", 32'(wb_tag), 32'(etg[s]));
            chk("wb_prec", 32'(wb_prec), 32'(epr[s]));
        end
        chk("busy", 32'(busy), 32'(mst == 1 || mst == 2));
        chk("done", 32'(done), 32'(mst == 3));
        chk("stall_cnt", 32'(stall_cnt), 32'(ecnt));
        if (wb_valid) begin
            wbc_log.push_back(cyc);
            wbd_log.push_back(wb_data);
        end
        if (done) done_log.push_back(cyc);
        if (xf) iss_log.push_back(cyc);
        if (STATS && mst == 1 && in_valid && !er && ecnt < 65535) ecnt++;
        resv[s] = 1'b0;
        if (xf) begin
            resv[(cyc + l) % 64] = 1'b1;
            edat[(cyc + l) % 64] = prod(in_a, in_b, cls_of(in_prec));
            etg[(cyc + l) % 64]  = in_tag;
            epr[(cyc + l) % 64]  = 2'(cls_of(in_prec));
        end
        case (mst)
            0: if (start) begin
                mst  = 1;
                ecnt = 0;
            end
            1: if (xf && in_last) mst = 2;
            2: begin
                pend = 1'b0;
                for (int k = 1; k <= 5; k++) begin
                    pend = pend | resv[(cyc + k) % 64];
                end
                if (!pend) mst = 3;
            end
            default: mst = 0;
        endcase
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_tag", 32'(wb_tag), 0);
        chk("rst_wb_prec", 32'(wb_prec), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mul_valid", 32'(mul_valid), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_job(input bit rnd_start, output int stalls);
        bit xf;
        int n;
        stalls   = 0;
        start    = 1'b1;
        in_valid = 1'b0;
        tick(xf);
        start = 1'b0;
        foreach (ops[i]) begin
            in_valid = 1'b0;
            repeat (ops[i].gap) tick(xf);
            in_a     = ops[i].a;
            in_b     = ops[i].b;
            in_prec  = ops[i].p;
            in_tag   = ops[i].t;
            in_last  = (i == ops.size() - 1);
            in_valid = 1'b1;
            n  = 0;
            xf = 1'b0;
            while (!xf && n < 40) begin
                start = rnd_start && ($urandom_range(0, 3) == 0);
                tick(xf);
                if (!xf) stalls++;
                n++;
            end
            start = 1'b0;
            if (!xf) chk("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (mst != 0 && n < 40) begin
            tick(xf);
            n++;
        end
        chk("job_end_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        bit xf;
        int t0;
        #2;
        do_reset();

        // Single INT4 op: 3*5 retires two cycles after issue.
        clear_logs();
        ops.delete();
        ops.push_back('{a: 16'd3, b: 16'd5, p: 4'd0, t: 6'd1, gap: 0});
        run_job(1'b0, st);
        chk("r30_wbcount", 32'(wbc_log.size()), 1);
        if (wbc_log.size() == 1 && iss_log.size() == 1) begin
            chk("r30_data", wbd_log[0], 32'd15);
            chk("r30_lat", 32'(wbc_log[0] - iss_log[0]), 2);
        end

        // Full16 then INT8 two cycles later: one stall, results at t+5, t+6.
        clear_logs();
        ops.delete();
        ops.push_back('{a: 16'd300, b: 16'd200, p: 4'd2, t: 6'd2, gap: 0});
        ops.push_back('{a: 16'd7, b: 16'd9, p: 4'd1, t: 6'd3, gap: 1});
        run_job(1'b0, st);
        chk("r31_stalls", 32'(st), 1);
        chk("r35_stall_cnt", 32'(stall_cnt), STATS ? 32'd1 : 32'd0);
        chk("r31_wbcount", 32'(wbc_log.size()), 2);
        if (wbc_log.size() == 2 && iss_log.size() == 2) begin
            chk("r31_issue2", 32'(iss_log[1] - iss_log[0]), 3);
            chk("r31_wb0_lat", 32'(wbc_log[0] - iss_log[0]), 5);
            chk("r31_wb0_data", wbd_log[0], 32'd60000);
            chk("r31_wb1_lat", 32'(wbc_log[1] - iss_log[0]), 6);
            chk("r31_wb1_data", wbd_log[1], 32'd63);
        end

        // Eight back-to-back INT8 ops: no stalls, in-order consecutive wb.
        clear_logs();
        ops.delete();
        for (int i = 1; i <= 8; i++) begin
            ops.push_back('{a: 16'(i), b: 16'd2, p: 4'd1, t: 6'(i), gap: 0});
        end
        run_job(1'b0, st);
        chk("r32_stalls", 32'(st), 0);
        chk("r32_wbcount", 32'(wbc_log.size()), 8);
        if (wbc_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("r32_data", wbd_log[i], 32'(2 * (i + 1)));
                chk("r32_cyc", 32'(wbc_log[i] - wbc_log[0]), 32'(i));
            end
        end

        // Last op full16: final wb t+5, done t+6.
        clear_logs();
        ops.delete();
        ops.push_back('{a: 16'hFFFF, b: 16'hFFFF, p: 4'd9, t: 6'd33, gap: 0});
        run_job(1'b0, st);
        if (iss_log.size() == 1 && wbc_log.size() == 1 &&
            done_log.size() == 1) begin
            chk("r33_wb_lat", 32'(wbc_log[0] - iss_log[0]), 5);
            chk("r33_done_lat", 32'(done_log[0] - iss_log[0]), 6);
            chk("r33_data", wbd_log[0], 32'hFFFE_0001);
        end else begin
            chk("r33_logs", 32'(done_log.size()), 1);
        end

        // Reset with three products in flight.
        start    = 1'b1;
        in_valid = 1'b0;
        tick(xf);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a     = 16'(100 + i);
            in_b     = 16'd3;
            in_prec  = 4'd2;
            in_tag   = 6'(40 + i);
            in_last  = 1'b0;
            in_valid = 1'b1;
            tick(xf);
        end
        do_reset();
        clear_logs();
        repeat (8) tick(xf);
        chk("r34_no_wb", 32'(wbc_log.size()), 0);
        ops.delete();
        ops.push_back('{a: 16'd3, b: 16'd5, p: 4'd0, t: 6'd1, gap: 0});
        run_job(1'b0, st);
        chk("r34_restart_wb", 32'(wbc_log.size()), 1);

        // Randomized jobs: mixed precisions, bubbles, stray start pulses.
        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(1, 12);
            ops.delete();
            for (int i = 0; i < n; i++) begin
                op_t o;
                o.a   = 16'($urandom);
                o.b   = 16'($urandom);
                o.p   = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
                        4'($urandom_range(0, 2));
                o.t   = 6'($urandom);
                o.gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                ops.push_back(o);
            end
            run_job(1'b1, st);
            if (j % 10 == 9) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/prec_mul_scheduler.md
PREC_MUL_SCHEDULER -- requirements
Module: prec_mul_scheduler

Interface
REQ-001 SHALL have parameter TAG_W, default 6, the width of the request/result tag.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have start  input  1  one-cycle pulse that begins a job; ignored outside IDLE.
REQ-005 SHALL have in_valid / in_ready  input / output  1 / 1  operand handshake; transfer when both are high.
REQ-006 SHALL have in_a, in_b  input  16 each  operand bit patterns.
REQ-007 SHALL have in_prec  input  4  precision code: 0=INT4, 1=INT8, >=2=full16.
REQ-008 SHALL have in_tag  input  TAG_W  requester tag; in_last  input  1  marks final operand pair of the job.
REQ-009 SHALL have mul_valid  output  1  and mul_a, mul_b  output  16 each  multiplier launch port.
REQ-010 SHALL have mul_p4  input  8; mul_p8  input  16; mul_p16  input  32  multiplier progressive products.
REQ-011 SHALL have wb_valid  output  1; wb_data  output  32; wb_tag  output  TAG_W; wb_prec  output  2  result writeback.
REQ-012 SHALL have busy  output  1; done  output  1  one-cycle job-complete pulse; stall_cnt  output  16.

Function
REQ-013 Multiplier latency from a mul_valid cycle t is fixed: p4 valid at t+2, p8 at t+3, p16 at t+5. Class latency Lc = 2 / 3 / 5 for prec 0 / 1 / >=2.
REQ-014 FSM states are IDLE, RUN, DRAIN, DONE. Transitions: IDLE->RUN on start; RUN->DRAIN on accepted in_last; DRAIN->DONE when no slot is reserved; DONE->IDLE unconditionally.
REQ-015 Slot table: 5 entries indexed 1..5 (cycles until writeback). Each entry holds {res, tag, prec2}. Every cycle the table shifts toward index 1, and entry 1 retires.
REQ-016 in_ready SHALL equal (state==RUN) && !res_next[Lc(in_prec)], where res_next is the post-shift table. in_ready is combinational on in_prec.
REQ-017 On transfer: mul_valid=1 and mul_a/mul_b=in_a/in_b in the same cycle (combinational pass-through). Entry Lc is written with {1, in_tag, class}.
REQ-018 When no transfer occurs: mul_valid=0 and mul_a/mul_b=0.
REQ-019 Retirement: registered wb_valid=1 the cycle the reserved product is available. wb_tag and wb_prec come from the entry.
REQ-020 wb_data is the zero-extended raw product: {24'd0,p4}, {16'd0,p8}, or p16. No scaling is applied; the consumer scales.
REQ-021 At most one wb per cycle. Results may retire out of issue order; wb_tag disambiguates.
REQ-022 Full throughput: same-class operands issue one per cycle with no stall.
REQ-023 busy=1 in RUN and DRAIN. done=1 only in DONE.
REQ-024 start asserted in RUN, DRAIN or DONE SHALL be ignored.
REQ-025 in_valid with in_last, presented while res_next[Lc] is set, SHALL stall like any other operand; the transition to DRAIN occurs only on actual transfer.

Reset
REQ-026 Asynchronous reset SHALL force: state=IDLE; all slot entries cleared; mul_valid, wb_valid, done, busy, in_ready=0; wb_data, wb_tag, wb_prec, stall_cnt=0.
REQ-027 Reset mid-job SHALL discard in-flight products; no wb_valid SHALL occur after release until a new issue.

Configuration
REQ-028 Macro PMS_STATS_EN defined: stall_cnt increments (saturating at 16'hFFFF) each RUN cycle with in_valid=1 and in_ready=0. It clears on reset and on IDLE->RUN.
REQ-029 PMS_STATS_EN undefined: stall_cnt SHALL be tied to 0 and no counter logic is synthesized.

Verification
REQ-030 start; prec0 a=3,b=5 tag=1 issued cycle t -> wb_valid at t+2, wb_data=15, wb_tag=1, wb_prec=0.
REQ-031 prec2 a=300,b=200 issued t, then prec1 presented at t+2 -> in_ready=0 at t+2, issue at t+3. Retire 60000 at t+5 and the INT8 result at t+6.
REQ-032 8 back-to-back prec1 ops, a=i,b=2 -> zero stall cycles, 8 consecutive wb with data 2*i, in order.
REQ-033 in_last accepted at t with prec2 -> in_ready=0 from t+1, final wb at t+5, done=1 at t+6, busy=0 at t+7.
REQ-034 Reset asserted with 3 ops in flight -> no wb_valid after release; state IDLE; start restarts cleanly.
REQ-035 With PMS_STATS_EN, the REQ-031 sequence leaves stall_cnt=1. Without it, stall_cnt stays 0.
